// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: instruction-memory fetch responder for the RV32I PC path.
// Takes byte-address fetches over valid/ready. Reads a synchronous word RAM and
// queues {instr, addr, fault} responses for a second valid/ready consumer.
// Ports:
//   clk, Areset (async, active-low)
//   req_valid/req_ready/req_addr : fetch request channel
//   rsp_valid/rsp_ready/rsp_instr/rsp_addr/rsp_fault : response channel
//   flush : drop the in-flight read and all queued responses
//   prog_we/prog_addr/prog_data : RAM programming port
module imem_fetch_responder #(
   parameter int MEM_WORDS = 256,
   parameter int AW        = 8,
   parameter int QDEPTH    = 3
) (
   input  logic          clk,
   input  logic          Areset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_addr,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_instr,
   output logic [31:0]   rsp_addr,
   output logic          rsp_fault,
   input  logic          flush,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [31:0]   prog_data
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   r_mem [MEM_WORDS];
   logic [31:0]   r_rd_data;

   logic          r_inflight;
   logic [31:0]   r_if_addr;
   logic          r_if_fault;

   logic [31:0]   r_q_instr [QDEPTH];
   logic [31:0]   r_q_addr  [QDEPTH];
   logic          r_q_fault [QDEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_nonempty;
   logic          w_fault;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_push_instr;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credit counts the in-flight read so a push never finds the queue full,
   // independent of what the consumer does.
   assign req_ready = Areset && !flush &&
                      ((int'(r_count) + int'(r_inflight)) < QDEPTH);

   assign w_accept   = req_valid && req_ready;
   assign w_idx      = req_addr[AW+1:2];
   assign w_fault    = (req_addr[1:0] != 2'b00) ||
                       (req_addr[31:2] >= 30'(MEM_WORDS));
   assign w_nonempty = (r_count != '0);
   assign w_push     = r_inflight && !flush;
   assign w_pop      = w_nonempty && rsp_ready && !flush;

   // Faulted fetches never expose RAM contents.
   assign w_push_instr = r_if_fault ? NOP : r_rd_data;

   assign rsp_valid = w_nonempty;
   assign rsp_instr = w_nonempty ? r_q_instr[r_rd_ptr] : 32'h0;
   assign rsp_addr  = w_nonempty ? r_q_addr[r_rd_ptr]  : 32'h0;
   assign rsp_fault = w_nonempty ? r_q_fault[r_rd_ptr] : 1'b0;

   // Read-first RAM: the fetch read samples the array before the write lands.
   always_ff @(posedge clk) begin
      if (prog_we) begin
         r_mem[prog_addr] <= prog_data;
      end
      if (w_accept) begin
         r_rd_data <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_instr[r_wr_ptr] <= w_push_instr;
         r_q_addr[r_wr_ptr]  <= r_if_addr;
         r_q_fault[r_wr_ptr] <= r_if_fault;
      end
   end

   always_ff @(posedge clk or negedge Areset) begin
      if (!Areset) begin
         r_inflight <= 1'b0;
         r_if_addr  <= 32'h0;
         r_if_fault <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else if (flush) begin
         r_inflight <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_accept;
         if (w_accept) begin
            r_if_addr  <= req_addr;
            r_if_fault <= w_fault;
         end
         if (w_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed bench for imem_fetch_responder.
// Table-driven single fetches plus hand-written multi-cycle sequences.
module tb_imem_fetch_responder;

   logic        clk;
   logic        Areset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_fault;
   logic        flush;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [31:0] prog_data;

   int n_vec;
   int n_err;

   imem_fetch_responder #(
      .MEM_WORDS(256),
      .AW(8),
      .QDEPTH(3)
   ) dut (
      .clk(clk),
      .Areset(Areset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr),
      .rsp_addr(rsp_addr),
      .rsp_fault(rsp_fault),
      .flush(flush),
      .prog_we(prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        fault;
   } vec_t;

   vec_t tbl [7];

   // Programmed image: word k = A000_000k, except word 1 holds addi x1,x0,5.
   function automatic logic [31:0] img(input int k);
      if (k == 1) return 32'h0050_0093;
      return 32'hA000_0000 | 32'(k);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Single fetch into an idle responder, popped once checked.
   task automatic fetch_one(input string nm, input logic [31:0] a,
                            input logic [31:0] ei, input logic ef);
      chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = a;
      @(negedge clk);
      req_valid = 1'b0;
      chk({nm, " valid_early"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({nm, " valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " instr"}, rsp_instr, ei);
      chk({nm, " addr"}, rsp_addr, a);
      chk({nm, " fault"}, 32'(rsp_fault), 32'(ef));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({nm, " drained"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] bp_list [4];
      int idx;
      int got;
      logic acc_pending;

      n_vec = 0;
      n_err = 0;
      tbl[0] = '{32'h0000_0004, 32'h0050_0093, 1'b0};
      tbl[1] = '{32'h0000_0000, 32'hA000_0000, 1'b0};
      tbl[2] = '{32'h0000_003C, 32'hA000_000F, 1'b0};
      tbl[3] = '{32'h0000_0006, 32'h0000_0013, 1'b1};
      tbl[4] = '{32'h0000_0400, 32'h0000_0013, 1'b1};
      tbl[5] = '{32'h0000_03FC, 32'hCAFE_00FF, 1'b0};
      tbl[6] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};
      bp_list[0] = 32'h0;
      bp_list[1] = 32'h4;
      bp_list[2] = 32'h8;
      bp_list[3] = 32'hC;

      Areset    = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      rsp_ready = 1'b0;
      flush     = 1'b0;
      prog_we   = 1'b0;
      prog_addr = 8'h0;
      prog_data = 32'h0;

      #1;
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst rsp_instr", rsp_instr, 32'd0);
      chk("rst rsp_addr", rsp_addr, 32'd0);
      chk("rst rsp_fault", 32'(rsp_fault), 32'd0);

      // RAM programming works while reset is held.
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         prog_we   = 1'b1;
         prog_addr = 8'(k);
         prog_data = img(k);
      end
      @(negedge clk);
      prog_addr = 8'hFF;
      prog_data = 32'hCAFE_00FF;
      @(negedge clk);
      prog_we = 1'b0;
      Areset  = 1'b1;
      #1;
      chk("release req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         fetch_one($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].instr,
                   tbl[i].fault);
      end

      // Streaming: 16 back-to-back fetches with the consumer always ready.
      rsp_ready = 1'b1;
      for (int c = 0; c < 19; c++) begin
         if (c < 16) begin
            req_valid = 1'b1;
            req_addr  = 32'(c * 4);
            chk($sformatf("stream ready c%0d", c), 32'(req_ready), 32'd1);
         end else begin
            req_valid = 1'b0;
         end
         if (c >= 2 && c < 18) begin
            chk($sformatf("stream valid c%0d", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("stream instr c%0d", c), rsp_instr, img(c - 2));
            chk($sformatf("stream addr c%0d", c), rsp_addr, 32'((c - 2) * 4));
         end
         if (c == 18) begin
            chk("stream tail empty", 32'(rsp_valid), 32'd0);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b0;

      // Backpressure: only QDEPTH accepts with the consumer stalled.
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         req_valid = 1'b1;
         req_addr  = bp_list[idx];
         if (req_ready) idx++;
         @(negedge clk);
      end
      chk("bp accepts", 32'(idx), 32'd3);
      chk("bp req_ready low", 32'(req_ready), 32'd0);
      chk("bp head addr", rsp_addr, 32'h0);
      rsp_ready   = 1'b1;
      got         = 0;
      acc_pending = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (acc_pending) req_valid = 1'b0;
         if (req_valid && req_ready) acc_pending = 1'b1;
         if (rsp_valid && got < 4) begin
            chk($sformatf("bp drain addr %0d", got), rsp_addr, bp_list[got]);
            chk($sformatf("bp drain instr %0d", got), rsp_instr, img(got));
            got++;
         end
         @(negedge clk);
      end
      chk("bp drained count", 32'(got), 32'd4);
      chk("bp empty", 32'(rsp_valid), 32'd0);
      req_valid = 1'b0;
      rsp_ready = 1'b0;

      // Flush with two queued entries and one read in flight.
      for (int c = 0; c < 3; c++) begin
         req_valid = 1'b1;
         req_addr  = 32'(c * 4);
         @(negedge clk);
      end
      req_valid = 1'b1;
      req_addr  = 32'h20;
      chk("pre-flush valid", 32'(rsp_valid), 32'd1);
      flush     = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("flush blocks req", 32'(req_ready), 32'd0);
      @(negedge clk);
      flush     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("post-flush valid", 32'(rsp_valid), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("no stale %0d", c), 32'(rsp_valid), 32'd0);
      end
      fetch_one("post-flush fetch", 32'h10, img(4), 1'b0);

      // Read-first: write word 2 on the same edge that fetches it.
      req_valid = 1'b1;
      req_addr  = 32'h8;
      prog_we   = 1'b1;
      prog_addr = 8'h02;
      prog_data = 32'hDEAD_BEEF;
      @(negedge clk);
      req_valid = 1'b0;
      prog_we   = 1'b0;
      @(negedge clk);
      chk("rf valid", 32'(rsp_valid), 32'd1);
      chk("rf old data", rsp_instr, img(2));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      fetch_one("rf new data", 32'h8, 32'hDEAD_BEEF, 1'b0);

      // Mid-run reset with a full queue.
      for (int c = 0; c < 5; c++) begin
         req_valid = req_ready;
         req_addr  = 32'h3C;
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("full queue valid", 32'(rsp_valid), 32'd1);
      chk("full queue no credit", 32'(req_ready), 32'd0);
      #2;
      Areset = 1'b0;
      #1;
      chk("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid rst req_ready", 32'(req_ready), 32'd0);
      chk("mid rst rsp_addr", rsp_addr, 32'd0);
      @(negedge clk);
      Areset = 1'b1;
      #1;
      chk("post rst req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      chk("post rst empty", 32'(rsp_valid), 32'd0);
      fetch_one("post rst fetch", 32'h3C, img(15), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
